dm_cache_ctrl: RTL and testbench

- Direct-mapped cache controller that drives the existing valid_mem and owns the tag/data arrays.
- Sits between the CPU load/store port and the main-memory port of the memory sub-system.
- Accepts one CPU request at a time and checks valid bit plus tag.
- Read miss: refills one word from memory. Write: write-through, no-write-allocate.

---
 rtl/memory_sub_system_param.sv | 22 ++
 rtl/dm_tag_data_array.sv | 46 ++++
 rtl/valid_mem.sv | 34 +++
 rtl/dm_cache_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_sub_system_param.sv
// Shared parameters and types for the memory sub-system.
// Contents:
//   ADDRESS_WIDTH  - CPU/memory byte-address width
//   DATA_WIDTH     - word width, one word per cache line
//   INDEX_LENGTH   - cache index bits (NUM_CACHE_LINES = 2**INDEX_LENGTH)
//   TAG_LENGTH     - tag bits stored per cache line
//   cache_state_t  - cache controller FSM states
package memory_sub_system_param;

   localparam int ADDRESS_WIDTH = 32;
   localparam int DATA_WIDTH    = 32;
   localparam int INDEX_LENGTH  = 4;
   localparam int TAG_LENGTH    = ADDRESS_WIDTH - INDEX_LENGTH - 2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COMPARE   = 2'd1,
      REFILL    = 2'd2,
      WRITE_MEM = 2'd3
   } cache_state_t;

endpackage

// File: rtl/dm_tag_data_array.sv
// Tag and data storage for the direct-mapped cache.
// Ports:
//   clk      - clock, writes on rising edge
//   index    - line index for reads and writes
//   tag_we   - write tag_in to the tag array at index
//   tag_in   - tag to store
//   data_we  - write data_in to the data array at index
//   data_in  - data word to store
//   tag_out  - combinational tag read at index
//   data_out - combinational data read at index
// Contents are not reset; the valid bits decide whether a line is usable.
module dm_tag_data_array
   import memory_sub_system_param::*;
#(
   parameter int INDEX_LENGTH = memory_sub_system_param::INDEX_LENGTH,
   parameter int TAG_LENGTH   = memory_sub_system_param::TAG_LENGTH,
   parameter int DATA_WIDTH   = memory_sub_system_param::DATA_WIDTH
) (
   input  logic                    clk,
   input  logic [INDEX_LENGTH-1:0] index,
   input  logic                    tag_we,
   input  logic [TAG_LENGTH-1:0]   tag_in,
   input  logic                    data_we,
   input  logic [DATA_WIDTH-1:0]   data_in,
   output logic [TAG_LENGTH-1:0]   tag_out,
   output logic [DATA_WIDTH-1:0]   data_out
);

   localparam int NUM_CACHE_LINES = 2 ** INDEX_LENGTH;

   logic [TAG_LENGTH-1:0] tag_mem  [NUM_CACHE_LINES];
   logic [DATA_WIDTH-1:0] data_mem [NUM_CACHE_LINES];

   always_ff @(posedge clk) begin
      if (tag_we) begin
         tag_mem[index] <= tag_in;
      end
      if (data_we) begin
         data_mem[index] <= data_in;
      end
   end

   assign tag_out  = tag_mem[index];
   assign data_out = data_mem[index];

endmodule

// File: rtl/valid_mem.sv
// Per-line valid bits for the direct-mapped cache.
// Ports:
//   clk       - clock, bits set on rising edge
//   resetn    - asynchronous active-low reset, clears every bit
//   index     - line index addressed for both read and write
//   we        - set the bit at index on the next rising edge
//   valid_out - combinational read of the bit at index
module valid_mem
   import memory_sub_system_param::*;
#(
   parameter int INDEX_LENGTH = memory_sub_system_param::INDEX_LENGTH
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [INDEX_LENGTH-1:0] index,
   input  logic                    we,
   output logic                    valid_out
);

   localparam int NUM_CACHE_LINES = 2 ** INDEX_LENGTH;

   logic [NUM_CACHE_LINES-1:0] valid_bits_reg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_bits_reg <= '0;
      end else if (we) begin
         valid_bits_reg[index] <= 1'b1;
      end
   end

   assign valid_out = valid_bits_reg[index];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// One word per line; one outstanding CPU request at a time.
// Ports:
//   clk, resetn     - clock (rising edge) and asynchronous active-low reset
//   cpu_req/we/addr/wdata - CPU request, held by the CPU until cpu_ready
//   cpu_ready       - high in IDLE, request accepted on that edge
//   cpu_resp_valid  - one-cycle completion pulse
//   cpu_rdata       - load data, holds its value between responses
//   mem_req/we/addr/wdata - main-memory request, held until mem_ready
//   mem_ready       - memory completes the current request this cycle
//   mem_rdata       - memory read data, valid with mem_ready
module dm_cache_ctrl
   import memory_sub_system_param::*;
#(
   parameter int ADDRESS_WIDTH = memory_sub_system_param::ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = memory_sub_system_param::DATA_WIDTH,
   parameter int INDEX_LENGTH  = memory_sub_system_param::INDEX_LENGTH,
   parameter int TAG_LENGTH    = ADDRESS_WIDTH - INDEX_LENGTH - 2
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     cpu_req,
   input  logic                     cpu_we,
   input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0]    cpu_wdata,
   output logic                     cpu_ready,
   output logic                     cpu_resp_valid,
   output logic [DATA_WIDTH-1:0]    cpu_rdata,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic                     mem_ready,
   input  logic [DATA_WIDTH-1:0]    mem_rdata
);

   localparam int WORD_ADDR_WIDTH = ADDRESS_WIDTH - 2;

   cache_state_t                 state_reg;
   logic [WORD_ADDR_WIDTH-1:0]   word_addr_reg;
   logic                         we_reg;
   logic [DATA_WIDTH-1:0]        wdata_reg;

   logic [INDEX_LENGTH-1:0]      req_index;
   logic [TAG_LENGTH-1:0]        req_tag;
   logic [TAG_LENGTH-1:0]        stored_tag;
   logic [DATA_WIDTH-1:0]        stored_data;
   logic                         valid_out;
   logic                         hit;
   logic                         refill_done;
   logic                         array_tag_we;
   logic                         array_data_we;
   logic [DATA_WIDTH-1:0]        array_data_in;

   // Byte-offset bits never reach the cache or memory.
   logic                         unused_byte_offset;
   assign unused_byte_offset = ^cpu_addr[1:0];

   assign req_index = word_addr_reg[INDEX_LENGTH-1:0];
   assign req_tag   = word_addr_reg[WORD_ADDR_WIDTH-1:INDEX_LENGTH];

   assign cpu_ready   = (state_reg == IDLE);
   assign hit         = valid_out && (stored_tag == req_tag);
   assign refill_done = (state_reg == REFILL) && mem_ready;

   // Data array is written by a store hit (in COMPARE) or a completed refill;
   // tag and valid only change on refill, so stores never allocate.
   assign array_tag_we  = refill_done;
   assign array_data_we = refill_done ||
                          ((state_reg == COMPARE) && we_reg && hit);
   assign array_data_in = refill_done ? mem_rdata : wdata_reg;

   valid_mem #(
      .INDEX_LENGTH (INDEX_LENGTH)
   ) u_valid_mem (
      .clk       (clk),
      .resetn    (resetn),
      .index     (req_index),
      .we        (refill_done),
      .valid_out (valid_out)
   );

   dm_tag_data_array #(
      .INDEX_LENGTH (INDEX_LENGTH),
      .TAG_LENGTH   (TAG_LENGTH),
      .DATA_WIDTH   (DATA_WIDTH)
   ) u_tag_data_array (
      .clk      (clk),
      .index    (req_index),
      .tag_we   (array_tag_we),
      .tag_in   (req_tag),
      .data_we  (array_data_we),
      .data_in  (array_data_in),
      .tag_out  (stored_tag),
      .data_out (stored_data)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg      <= IDLE;
         word_addr_reg  <= '0;
         we_reg         <= 1'b0;
         wdata_reg      <= '0;
         cpu_resp_valid <= 1'b0;
         cpu_rdata      <= '0;
         mem_req        <= 1'b0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
      end else begin
         cpu_resp_valid <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (cpu_req) begin
                  word_addr_reg <= cpu_addr[ADDRESS_WIDTH-1:2];
                  we_reg        <= cpu_we;
                  wdata_reg     <= cpu_wdata;
                  state_reg     <= COMPARE;
               end
            end
            COMPARE: begin
               if (!we_reg && hit) begin
                  cpu_rdata      <= stored_data;
                  cpu_resp_valid <= 1'b1;
                  state_reg      <= IDLE;
               end else if (!we_reg) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= {word_addr_reg, 2'b00};
                  state_reg <= REFILL;
               end else begin
                  // Write-through for both store hit and store miss.
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= {word_addr_reg, 2'b00};
                  mem_wdata <= wdata_reg;
                  state_reg <= WRITE_MEM;
               end
            end
            REFILL: begin
               if (mem_ready) begin
                  cpu_rdata      <= mem_rdata;
                  cpu_resp_valid <= 1'b1;
                  mem_req        <= 1'b0;
                  mem_we         <= 1'b0;
                  state_reg      <= IDLE;
               end
            end
            WRITE_MEM: begin
               if (mem_ready) begin
                  cpu_resp_valid <= 1'b1;
                  mem_req        <= 1'b0;
                  mem_we         <= 1'b0;
                  state_reg      <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl: stimulus pushes expected CPU responses
// and expected memory transactions; a monitor and a memory model pop them.
module tb_dm_cache_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_ready;
   logic        cpu_resp_valid;
   logic [31:0] cpu_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   typedef struct {
      logic [31:0] rdata;
      int          lat;
      int          acc;
   } exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
   } mem_t;

   exp_t exp_q[$];
   mem_t mem_q[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   dm_cache_ctrl #(
      .ADDRESS_WIDTH (32),
      .DATA_WIDTH    (32),
      .INDEX_LENGTH  (4)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .cpu_req        (cpu_req),
      .cpu_we         (cpu_we),
      .cpu_addr       (cpu_addr),
      .cpu_wdata      (cpu_wdata),
      .cpu_ready      (cpu_ready),
      .cpu_resp_valid (cpu_resp_valid),
      .cpu_rdata      (cpu_rdata),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_ready      (mem_ready),
      .mem_rdata      (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // CPU response monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (resetn && cpu_resp_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_resp", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               $display("resp: rdata=%h latency=%0d (expected %h / %0d)",
                        cpu_rdata, cyc - e.acc + 1, e.rdata, e.lat);
               check("resp_rdata", cpu_rdata, e.rdata);
               check("resp_latency", cyc - e.acc + 1, e.lat);
            end
         end
      end
   end

   // Main-memory model: checks each request, answers after 'delay' cycles
   initial begin
      mem_t m;
      bit   aborted;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_ready = 1'b0;
         if (resetn && mem_req) begin
            if (mem_q.size() == 0) begin
               check("unexpected_mem_req", 32'd1, 32'd0);
               m = '{1'b0, 32'h0, 32'h0, 32'h0, 1};
            end else begin
               m = mem_q.pop_front();
               $display("mem: we=%0d addr=%h wdata=%h", mem_we, mem_addr, mem_wdata);
               check("mem_we", {31'd0, mem_we}, {31'd0, m.we});
               check("mem_addr", mem_addr, m.addr);
               if (m.we) check("mem_wdata", mem_wdata, m.wdata);
            end
            aborted = 1'b0;
            for (int k = 1; k < m.delay; k++) begin
               @(negedge clk);
               if (!mem_req) begin
                  aborted = 1'b1;
                  break;
               end
            end
            if (!aborted) begin
               mem_rdata = m.rdata;
               mem_ready = 1'b1;
            end
         end
      end
   end

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input int exp_lat, input bit push_exp);
      int waited = 0;
      @(negedge clk);
      while (!cpu_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!cpu_ready) begin
         check("cpu_ready_timeout", 32'd0, 32'd1);
         return;
      end
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      if (push_exp) exp_q.push_back('{exp_rdata, exp_lat, cyc});
   endtask

   task automatic load(input logic [31:0] addr, input logic [31:0] exp_rdata, input int exp_lat);
      do_req(1'b0, addr, 32'h0, exp_rdata, exp_lat, 1'b1);
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] held_rdata, input int exp_lat);
      do_req(1'b1, addr, wdata, held_rdata, exp_lat, 1'b1);
   endtask

   // Stimulus
   initial begin
      int waited;
      resetn    = 1'b0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
      check("rst_rdata", cpu_rdata, 32'h0);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      resetn = 1'b1;
      #1;
      check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd1);

      // 1: cold miss, memory answers in third REFILL cycle
      mem_q.push_back('{1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 3});
      load(32'h10, 32'hDEAD_BEEF, 5);

      // 2: back-to-back hits
      load(32'h10, 32'hDEAD_BEEF, 2);
      load(32'h10, 32'hDEAD_BEEF, 2);
      load(32'h10, 32'hDEAD_BEEF, 2);

      // 3: store hit with immediate mem_ready, cpu_rdata unchanged; then hit
      mem_q.push_back('{1'b1, 32'h10, 32'h1234_5678, 32'h0, 1});
      store(32'h10, 32'h1234_5678, 32'hDEAD_BEEF, 3);
      load(32'h10, 32'h1234_5678, 2);

      // 4: store miss does not allocate; following load misses
      mem_q.push_back('{1'b1, 32'h90, 32'hAAAA_5555, 32'h0, 2});
      store(32'h90, 32'hAAAA_5555, 32'h1234_5678, 4);
      mem_q.push_back('{1'b0, 32'h90, 32'h0, 32'hCAFE_0090, 1});
      load(32'h90, 32'hCAFE_0090, 3);

      // 5: conflict eviction on index 4
      mem_q.push_back('{1'b0, 32'h10, 32'h0, 32'h1234_5678, 1});
      load(32'h10, 32'h1234_5678, 3);
      mem_q.push_back('{1'b0, 32'h50, 32'h0, 32'h1111_0050, 2});
      load(32'h50, 32'h1111_0050, 4);
      mem_q.push_back('{1'b0, 32'h10, 32'h0, 32'h1234_5678, 1});
      load(32'h10, 32'h1234_5678, 3);
      load(32'h10, 32'h1234_5678, 2);

      // 6: reset during REFILL drops the transaction and clears valid bits
      mem_q.push_back('{1'b0, 32'h24, 32'h0, 32'hBAD0_0024, 10});
      do_req(1'b0, 32'h24, 32'h0, 32'h0, 0, 1'b0);
      repeat (2) @(negedge clk);
      check("refill_mem_req", {31'd0, mem_req}, 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
      check("midrst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
      check("midrst_cpu_ready", {31'd0, cpu_ready}, 32'd1);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      mem_q.push_back('{1'b0, 32'h10, 32'h0, 32'h1234_5678, 1});
      load(32'h10, 32'h1234_5678, 3);

      // Drain
      waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      repeat (4) @(negedge clk);
      check("exp_q_drained", exp_q.size(), 32'd0);
      check("mem_q_drained", mem_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
